// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier sequencing controller.
// Latency: n/a (types, constants and a constant-foldable helper only).
// Backpressure: n/a.
package booth_pkg;

  // Controller state encoding
  localparam int unsigned ST_W = 2;
  typedef logic [ST_W-1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t RUN  = 2'd2;
  localparam state_t DONE = 2'd3;

  // Number of add/shift steps for one multiplication.
  // Radix-2 retires one multiplier bit per step, radix-4 retires two.
  function automatic int unsigned steps_for(input int unsigned width, input logic mode);
    return mode ? (width / 2) : width;
  endfunction

endpackage

// File: rtl/booth_step_counter.sv
// Step index counter for the Booth datapath with terminal-count compare against N-1.
// Latency: count updates one cycle after en/clr; tc is combinational from the count and mode.
// Backpressure: none; the count saturates at N-1 and never wraps.
module booth_step_counter
  import booth_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Step totals for each recoding mode, folded at elaboration
  localparam int unsigned N_R2 = steps_for(WIDTH, 1'b0);
  localparam int unsigned N_R4 = steps_for(WIDTH, 1'b1);

  localparam logic [CNT_W-1:0] TERM_R2 = CNT_W'(N_R2 - 1);
  localparam logic [CNT_W-1:0] TERM_R4 = CNT_W'(N_R4 - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] term;

  // Terminal compare against the step total of the latched mode
  always_comb begin
    term = mode ? TERM_R4 : TERM_R2;
    tc   = (cnt_q == term);
  end

  // Clear wins over enable; hold at the terminal value so the count cannot wrap
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing controller for the Booth add/shift datapath: load, N steps, held result.
// Latency: start accepted at E0 -> load in cycle 1, step_en in cycles 2..N+1, result_valid from cycle N+2.
// Backpressure: start_ready only in IDLE; result_valid is held until result_ready; abort cancels LOAD/RUN.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  // Operand width; must be even and at least 4 so both radices give a whole step count
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic             mode_r4,
  input  logic             abort,
  output logic             load,
  output logic             step_en,
  output logic [CNT_W-1:0] step_cnt,
  output logic             last_step,
  output logic             mode_q,
  output logic             busy,
  output logic             result_valid,
  input  logic             result_ready
);

  state_t state_q;
  state_t state_d;
  logic   mode_d;

  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_tc;

  // Step index and terminal detect for the RUN phase
  booth_step_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_step_counter (
    .clk    (clk),
    .rst_in (rst_in),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .mode   (mode_q),
    .cnt    (step_cnt),
    .tc     (cnt_tc)
  );

  // State and latched-mode registers
  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; abort outranks the RUN->DONE exit
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          mode_d  = mode_r4;
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = abort ? IDLE : RUN;
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_tc) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore outputs and counter controls decoded from the state register
  always_comb begin
    start_ready  = 1'b0;
    load         = 1'b0;
    step_en      = 1'b0;
    last_step    = 1'b0;
    busy         = 1'b0;
    result_valid = 1'b0;
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
      end
      LOAD: begin
        load    = 1'b1;
        busy    = 1'b1;
        cnt_clr = 1'b1;
      end
      RUN: begin
        step_en   = 1'b1;
        busy      = 1'b1;
        last_step = cnt_tc;
        cnt_en    = 1'b1;
        // Leave the count at zero for the next operation whether we finish or abort
        cnt_clr   = abort || cnt_tc;
      end
      DONE: begin
        result_valid = 1'b1;
      end
      default: begin
        start_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
module tb_booth_seq_ctrl;

  logic clk = 1'b0;
  logic rst_in;
  logic sv, m4, ab, rr;

  logic sr_a, ld_a, se_a, ls_a, mq_a, bz_a, rv_a;
  logic [3:0] sc_a;
  logic sr_b, ld_b, se_b, ls_b, mq_b, bz_b, rv_b;
  logic [4:0] sc_b;

  always #5 clk = ~clk;

  booth_seq_ctrl #(.WIDTH(8)) dut_a (
    .clk(clk), .rst_in(rst_in), .start_valid(sv), .start_ready(sr_a), .mode_r4(m4),
    .abort(ab), .load(ld_a), .step_en(se_a), .step_cnt(sc_a), .last_step(ls_a),
    .mode_q(mq_a), .busy(bz_a), .result_valid(rv_a), .result_ready(rr)
  );

  booth_seq_ctrl #(.WIDTH(16)) dut_b (
    .clk(clk), .rst_in(rst_in), .start_valid(sv), .start_ready(sr_b), .mode_r4(m4),
    .abort(ab), .load(ld_b), .step_en(se_b), .step_cnt(sc_b), .last_step(ls_b),
    .mode_q(mq_b), .busy(bz_b), .result_valid(rv_b), .result_ready(rr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: t = cycles since the start was accepted (0 = idle),
  // n = step total chosen at acceptance, mq = mode latched at acceptance.
  int wd[2];
  int t[2];
  int n[2];
  bit mq[2];
  int se_cnt[2];
  int rv_cnt[2];

  task automatic chk(input string tag, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, i, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      t[i] = 0;
      n[i] = wd[i];
      mq[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (rst_in) begin
      for (int i = 0; i < 2; i++) begin
        if (t[i] == 0) begin
          if (sv) begin
            t[i] = 1;
            mq[i] = m4;
            n[i] = m4 ? wd[i] / 2 : wd[i];
          end
        end else if (t[i] <= n[i] + 1) begin
          t[i] = ab ? 0 : t[i] + 1;
        end else if (rr) begin
          t[i] = 0;
        end
      end
    end
  endtask

  task automatic check_model(input int i, input logic sr, input logic ld, input logic se,
                             input logic [31:0] sc, input logic ls, input logic mqv,
                             input logic bz, input logic rv);
    bit run;
    run = (t[i] >= 2) && (t[i] <= n[i] + 1);
    chk("start_ready", i, 32'(sr), 32'(t[i] == 0));
    chk("load", i, 32'(ld), 32'(t[i] == 1));
    chk("step_en", i, 32'(se), 32'(run));
    chk("step_cnt", i, sc, run ? 32'(t[i] - 2) : 32'd0);
    chk("last_step", i, 32'(ls), 32'(t[i] == n[i] + 1));
    chk("mode_q", i, 32'(mqv), 32'(mq[i]));
    chk("busy", i, 32'(bz), 32'((t[i] >= 1) && (t[i] <= n[i] + 1)));
    chk("result_valid", i, 32'(rv), 32'(t[i] == n[i] + 2));
  endtask

  task automatic check_all();
    check_model(0, sr_a, ld_a, se_a, 32'(sc_a), ls_a, mq_a, bz_a, rv_a);
    check_model(1, sr_b, ld_b, se_b, 32'(sc_b), ls_b, mq_b, bz_b, rv_b);
  endtask

  task automatic clr_cnt();
    se_cnt = '{0, 0};
    rv_cnt = '{0, 0};
  endtask

  // One clock: model advances on the edge, outputs are compared 1 time unit later
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    se_cnt[0] += int'(se_a);
    se_cnt[1] += int'(se_b);
    rv_cnt[0] += int'(rv_a);
    rv_cnt[1] += int'(rv_b);
  endtask

  initial begin
    wd = '{8, 16};
    rst_in = 1'b0;
    sv = 1'b0; m4 = 1'b0; ab = 1'b0; rr = 1'b0;
    model_reset();
    clr_cnt();

    // Reset state before any clock edge
    #2;
    check_all();
    tick();
    tick();
    rst_in = 1'b1;
    tick();

    // Radix-2: 8 and 16 steps
    clr_cnt();
    sv = 1'b1; m4 = 1'b0; rr = 1'b1;
    tick();
    sv = 1'b0;
    repeat (20) tick();
    chk("r2_steps", 0, 32'(se_cnt[0]), 32'd8);
    chk("r2_steps", 1, 32'(se_cnt[1]), 32'd16);
    chk("r2_results", 0, 32'(rv_cnt[0]), 32'd1);

    // Radix-4: 4 and 8 steps
    clr_cnt();
    sv = 1'b1; m4 = 1'b1;
    tick();
    sv = 1'b0;
    repeat (12) tick();
    chk("r4_steps", 0, 32'(se_cnt[0]), 32'd4);
    chk("r4_steps", 1, 32'(se_cnt[1]), 32'd8);

    // Result hold: consumer stalls 3 cycles, start during DONE is ignored
    clr_cnt();
    sv = 1'b1; m4 = 1'b1; rr = 1'b0;
    tick();
    sv = 1'b0;
    repeat (5) tick();
    sv = 1'b1;
    tick();
    tick();
    sv = 1'b0;
    tick();
    rr = 1'b1;
    tick();
    chk("hold_idle", 0, 32'(sr_a), 32'd1);
    repeat (3) tick();
    chk("hold_rv_cycles", 0, 32'(rv_cnt[0]), 32'd4);

    // Abort on the third RUN cycle
    clr_cnt();
    sv = 1'b1; m4 = 1'b0;
    tick();
    sv = 1'b0;
    repeat (3) tick();
    chk("abort_at_cnt", 0, 32'(sc_a), 32'd2);
    ab = 1'b1;
    tick();
    ab = 1'b0;
    chk("abort_idle", 0, 32'(sr_a), 32'd1);
    chk("abort_cnt", 1, 32'(sc_b), 32'd0);
    repeat (4) tick();
    chk("abort_no_rv", 0, 32'(rv_cnt[0] + rv_cnt[1]), 32'd0);
    clr_cnt();
    sv = 1'b1; m4 = 1'b1;
    tick();
    sv = 1'b0;
    repeat (12) tick();
    chk("post_abort_steps", 0, 32'(se_cnt[0]), 32'd4);
    chk("post_abort_steps", 1, 32'(se_cnt[1]), 32'd8);

    // Asynchronous reset in the middle of RUN
    sv = 1'b1; m4 = 1'b0;
    tick();
    sv = 1'b0;
    repeat (4) tick();
    #3 rst_in = 1'b0;
    #1;
    model_reset();
    check_all();
    tick();
    #2 rst_in = 1'b1;
    tick();

    // Randomised traffic with occasional aborts and consumer stalls
    repeat (800) begin
      sv = ($urandom_range(0, 3) == 0);
      m4 = 1'($urandom_range(0, 1));
      ab = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
